// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM RAM arbiter: master IDs, default widths
// and the starvation-counter width helper.
package mem_arbiter_pkg;

   localparam int unsigned XLEN_DEF       = 64;
   localparam int unsigned BE_W_DEF       = 8;
   localparam int unsigned STARVE_MAX_DEF = 4;

   typedef enum logic {
      ARB_M0 = 1'b0,
      ARB_M1 = 1'b1
   } arb_id_e;

   // Counter must be able to hold STARVE_MAX itself.
   function automatic int unsigned starve_w(input int unsigned max_cnt);
      return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_prio_starve.sv
// Grant logic for two requesters: M1 (LSU) has fixed priority, and a
// saturating starvation counter forces an M0 (fetch) grant after STARVE_MAX losses.
module arb_prio_starve
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic m0_req,
   input  logic m1_req,
   output logic m0_gnt,
   output logic m1_gnt
);

   localparam int unsigned      CNT_W   = starve_w(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             force_m0;

   always_comb begin
      force_m0 = m0_req && (starve_cnt == CNT_MAX);
      m1_gnt   = reset && m1_req && !force_m0;
      m0_gnt   = reset && m0_req && !m1_gnt;
   end

   // Counts only M1 wins that leave a waiting M0 behind.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!m0_req || m0_gnt) begin
         starve_cnt <= '0;
      end else if (m1_gnt && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch (M0) and load/store (M1):
// one command per cycle onto ram_*, 1-cycle read data routed back by a response tag.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN       = XLEN_DEF,
   parameter int unsigned BE_W       = BE_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            m0_req_i,
   input  logic [XLEN-1:0] m0_addr_i,
   output logic            m0_gnt_o,
   output logic            m0_rvalid_o,
   output logic [XLEN-1:0] m0_rdata_o,

   input  logic            m1_req_i,
   input  logic [XLEN-1:0] m1_addr_i,
   input  logic            m1_wen_i,
   input  logic [BE_W-1:0] m1_byte_en_i,
   input  logic [XLEN-1:0] m1_wdata_i,
   output logic            m1_gnt_o,
   output logic            m1_rvalid_o,
   output logic [XLEN-1:0] m1_rdata_o,

   output logic [XLEN-1:0] ram_addr_o,
   output logic            ram_wen_o,
   output logic [BE_W-1:0] ram_byte_en_o,
   output logic [XLEN-1:0] ram_wdata_o,
   output logic            ram_ren_o,
   input  logic [XLEN-1:0] ram_rdata_i
);

   logic    rsp_vld;
   arb_id_e rsp_id;

   arb_prio_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .m0_req (m0_req_i),
      .m1_req (m1_req_i),
      .m0_gnt (m0_gnt_o),
      .m1_gnt (m1_gnt_o)
   );

   // Grants are already gated by reset, so an idle or reset cycle drives all zeros.
   always_comb begin
      ram_addr_o    = '0;
      ram_wen_o     = 1'b0;
      ram_byte_en_o = '0;
      ram_wdata_o   = '0;
      ram_ren_o     = 1'b0;
      if (m1_gnt_o) begin
         ram_addr_o    = m1_addr_i;
         ram_wen_o     = m1_wen_i;
         ram_byte_en_o = m1_byte_en_i;
         ram_wdata_o   = m1_wdata_i;
         ram_ren_o     = !m1_wen_i;
      end else if (m0_gnt_o) begin
         ram_addr_o = m0_addr_i;
         ram_ren_o  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rsp_vld <= 1'b0;
         rsp_id  <= ARB_M0;
      end else begin
         rsp_vld <= ram_ren_o;
         rsp_id  <= m1_gnt_o ? ARB_M1 : ARB_M0;
      end
   end

   // Response is masked while reset is low so a read granted just before reset is dropped.
   always_comb begin
      m0_rvalid_o = reset && rsp_vld && (rsp_id == ARB_M0);
      m1_rvalid_o = reset && rsp_vld && (rsp_id == ARB_M1);
      m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
      m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
   end

   a_one_gnt: assert property (@(posedge clk) !(m0_gnt_o && m1_gnt_o))
      else $error("mem_arbiter: both masters granted in one cycle");

   a_m0_hold: assert property (@(posedge clk) disable iff (!reset)
      (m0_req_i && !m0_gnt_o) |=> (m0_req_i && $stable(m0_addr_i)))
      else $error("mem_arbiter: m0 request dropped or changed before grant");

   a_m1_hold: assert property (@(posedge clk) disable iff (!reset)
      (m1_req_i && !m1_gnt_o) |=> (m1_req_i && $stable(m1_addr_i) && $stable(m1_wen_i)
                                   && $stable(m1_byte_en_i) && $stable(m1_wdata_i)))
      else $error("mem_arbiter: m1 request dropped or changed before grant");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a behavioural 1-cycle RAM.
module tb_mem_arbiter;

   localparam int unsigned XLEN = 64;
   localparam int unsigned BE_W = 8;
   localparam int unsigned SMAX = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            m0_req = 1'b0;
   logic [XLEN-1:0] m0_addr = '0;
   logic            m0_gnt, m0_rvalid;
   logic [XLEN-1:0] m0_rdata;
   logic            m1_req = 1'b0;
   logic [XLEN-1:0] m1_addr = '0;
   logic            m1_wen = 1'b0;
   logic [BE_W-1:0] m1_be = '0;
   logic [XLEN-1:0] m1_wdata = '0;
   logic            m1_gnt, m1_rvalid;
   logic [XLEN-1:0] m1_rdata;
   logic [XLEN-1:0] ram_addr, ram_wdata;
   logic            ram_wen, ram_ren;
   logic [BE_W-1:0] ram_be;
   logic [XLEN-1:0] ram_rdata = '0;

   mem_arbiter #(
      .XLEN       (XLEN),
      .BE_W       (BE_W),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m0_req_i      (m0_req),
      .m0_addr_i     (m0_addr),
      .m0_gnt_o      (m0_gnt),
      .m0_rvalid_o   (m0_rvalid),
      .m0_rdata_o    (m0_rdata),
      .m1_req_i      (m1_req),
      .m1_addr_i     (m1_addr),
      .m1_wen_i      (m1_wen),
      .m1_byte_en_i  (m1_be),
      .m1_wdata_i    (m1_wdata),
      .m1_gnt_o      (m1_gnt),
      .m1_rvalid_o   (m1_rvalid),
      .m1_rdata_o    (m1_rdata),
      .ram_addr_o    (ram_addr),
      .ram_wen_o     (ram_wen),
      .ram_byte_en_o (ram_be),
      .ram_wdata_o   (ram_wdata),
      .ram_ren_o     (ram_ren),
      .ram_rdata_i   (ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] init_val(input int i);
      return (i == 8) ? 64'h13 : (64'hC0DE_0000_0000_0000 | 64'(i));
   endfunction

   // Behavioural RAM: 256 x 64-bit words, byte-enabled writes, registered reads.
   logic [63:0] mem [256];
   bit          loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else begin
         if (ram_wen)
            for (int b = 0; b < 8; b++)
               if (ram_be[b]) mem[ram_addr[10:3]][8*b +: 8] <= ram_wdata[8*b +: 8];
         if (ram_ren) ram_rdata <= mem[ram_addr[10:3]];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        r0;
      logic [63:0] a0;
      logic        r1;
      logic [63:0] a1;
      logic        w1;
      logic [7:0]  be;
      logic [63:0] wd;
      logic        g0;
      logic        g1;
      logic        ren;
      logic        wen;
      logic [63:0] ra;
      logic [7:0]  rbe;
      logic [63:0] rwd;
      logic        v0;
      logic [63:0] d0;
      logic        v1;
      logic [63:0] d1;
   } vec_t;

   vec_t vec [14];

   logic [63:0] shadow [256];
   logic [63:0] pa0, pa1, a0, a1, wd1, ed0, ed1;
   logic [7:0]  be1;
   logic        w1;
   bit          p0, p1, e0, e1, ev0, ev1, x0, x1;
   int          cnt, wait0;

   initial begin
      // rst r0 a0 r1 a1 w1 be wd | g0 g1 ren wen raddr rbe rwd | v0 d0 v1 d1
      vec[0]  = '{1'b0, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[1]  = vec[0];
      vec[2]  = vec[0];
      vec[3]  = '{1'b1, 1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 64'h40, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[4]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 64'h13, 1'b0, 64'h0};
      vec[5]  = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h100, 1'b1, 8'h0F, 64'h11223344,
                  1'b0, 1'b1, 1'b0, 1'b1, 64'h100, 8'h0F, 64'h11223344, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[6]  = '{1'b1, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[7]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 64'hC0DE_0000_1122_3344, 1'b0, 64'h0};
      vec[8]  = '{1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b1, 1'b1, 1'b0, 64'h80, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[9]  = '{1'b0, 1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[10] = '{1'b1, 1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 64'h40, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[11] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 64'h13, 1'b0, 64'h0};
      vec[12] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h88, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b1, 1'b1, 1'b0, 64'h88, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
      vec[13] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0, 1'b1, 64'hC0DE_0000_0000_0011};

      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

      // Directed table: one row per clock cycle.
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         reset    = vec[i].rst;
         m0_req   = vec[i].r0;
         m0_addr  = vec[i].a0;
         m1_req   = vec[i].r1;
         m1_addr  = vec[i].a1;
         m1_wen   = vec[i].w1;
         m1_be    = vec[i].be;
         m1_wdata = vec[i].wd;
         @(negedge clk);
         chk($sformatf("row%0d m0_gnt", i),    64'(m0_gnt),    64'(vec[i].g0));
         chk($sformatf("row%0d m1_gnt", i),    64'(m1_gnt),    64'(vec[i].g1));
         chk($sformatf("row%0d ram_ren", i),   64'(ram_ren),   64'(vec[i].ren));
         chk($sformatf("row%0d ram_wen", i),   64'(ram_wen),   64'(vec[i].wen));
         chk($sformatf("row%0d ram_addr", i),  ram_addr,       vec[i].ra);
         chk($sformatf("row%0d ram_be", i),    64'(ram_be),    64'(vec[i].rbe));
         chk($sformatf("row%0d ram_wdata", i), ram_wdata,      vec[i].rwd);
         chk($sformatf("row%0d m0_rvalid", i), 64'(m0_rvalid), 64'(vec[i].v0));
         chk($sformatf("row%0d m0_rdata", i),  m0_rdata,       vec[i].d0);
         chk($sformatf("row%0d m1_rvalid", i), 64'(m1_rvalid), 64'(vec[i].v1));
         chk($sformatf("row%0d m1_rdata", i),  m1_rdata,       vec[i].d1);
      end
      shadow[32] = 64'hC0DE_0000_1122_3344;

      // Both masters loading every cycle: M1,M1,M1,M1,M0 repeating, then drain.
      pa0 = 64'h300;
      pa1 = 64'h200;
      ev0 = 1'b0;
      ev1 = 1'b0;
      for (int c = 0; c < 17; c++) begin
         @(posedge clk); #1;
         m0_req   = (c < 15);
         m0_addr  = pa0;
         m1_req   = (c < 16);
         m1_addr  = pa1;
         m1_wen   = 1'b0;
         m1_be    = '0;
         m1_wdata = '0;
         @(negedge clk);
         x1 = (c < 16) && ((c % 5) != 4);
         x0 = (c < 15) && ((c % 5) == 4);
         chk($sformatf("pat%0d m0_gnt", c),    64'(m0_gnt),    64'(x0));
         chk($sformatf("pat%0d m1_gnt", c),    64'(m1_gnt),    64'(x1));
         chk($sformatf("pat%0d m0_rvalid", c), 64'(m0_rvalid), 64'(ev0));
         chk($sformatf("pat%0d m0_rdata", c),  m0_rdata,       ev0 ? ed0 : 64'h0);
         chk($sformatf("pat%0d m1_rvalid", c), 64'(m1_rvalid), 64'(ev1));
         chk($sformatf("pat%0d m1_rdata", c),  m1_rdata,       ev1 ? ed1 : 64'h0);
         ev0 = x0;
         ed0 = shadow[pa0[10:3]];
         ev1 = x1;
         ed1 = shadow[pa1[10:3]];
         if (x0) pa0 = pa0 + 64'h8;
         if (x1) pa1 = pa1 + 64'h8;
      end

      // Random request streams against a priority/starvation and memory model.
      p0 = 1'b0;
      p1 = 1'b0;
      ev0 = 1'b0;
      ev1 = 1'b0;
      cnt = 0;
      wait0 = 0;
      a0 = '0;
      a1 = '0;
      w1 = 1'b0;
      be1 = '0;
      wd1 = '0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!p0 && ($urandom_range(0, 3) != 0)) begin
            p0 = 1'b1;
            a0 = 64'($urandom_range(0, 255)) << 3;
         end
         if (!p1 && ($urandom_range(0, 2) != 0)) begin
            p1  = 1'b1;
            a1  = 64'($urandom_range(0, 255)) << 3;
            w1  = 1'($urandom_range(0, 1));
            be1 = 8'($urandom);
            wd1 = {$urandom, $urandom};
         end
         m0_req   = p0;
         m0_addr  = a0;
         m1_req   = p1;
         m1_addr  = a1;
         m1_wen   = w1;
         m1_be    = be1;
         m1_wdata = wd1;
         @(negedge clk);
         e1 = p1 && !(p0 && (cnt == SMAX));
         e0 = p0 && !e1;
         chk($sformatf("rnd%0d m0_gnt", c),    64'(m0_gnt),    64'(e0));
         chk($sformatf("rnd%0d m1_gnt", c),    64'(m1_gnt),    64'(e1));
         chk($sformatf("rnd%0d m0_rvalid", c), 64'(m0_rvalid), 64'(ev0));
         chk($sformatf("rnd%0d m0_rdata", c),  m0_rdata,       ev0 ? ed0 : 64'h0);
         chk($sformatf("rnd%0d m1_rvalid", c), 64'(m1_rvalid), 64'(ev1));
         chk($sformatf("rnd%0d m1_rdata", c),  m1_rdata,       ev1 ? ed1 : 64'h0);
         ev0 = e0;
         ed0 = shadow[a0[10:3]];
         ev1 = e1 && !w1;
         ed1 = shadow[a1[10:3]];
         if (e1 && w1)
            for (int b = 0; b < 8; b++)
               if (be1[b]) shadow[a1[10:3]][8*b +: 8] = wd1[8*b +: 8];
         if (p0) wait0++;
         if (m0_gnt) begin
            n_cmp++;
            if (wait0 > int'(SMAX + 1)) begin
               n_bad++;
               $display("FAIL rnd%0d m0_wait: got %0d cycles allowed %0d", c, wait0, SMAX + 1);
            end
            wait0 = 0;
         end
         if (!p0 || e0) cnt = 0;
         else if (e1 && (cnt < int'(SMAX))) cnt++;
         if (m0_gnt) p0 = 1'b0;
         if (m1_gnt) p1 = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
